// File: rtl/ingress_frame_fifo_pkg.sv
// Shared Ethernet ingress types: receive bus, read FSM states, default sizes and drop-event helpers.
package ingress_frame_fifo_pkg;

    localparam int DEFAULT_DEPTH      = 1024;
    localparam int DEFAULT_MAX_FRAMES = 32;

    typedef struct packed {
        logic        start;
        logic        data_valid;
        logic [2:0]  bytes_valid;
        logic [31:0] data;
        logic        commit;
        logic        drop;
    } EthernetRxBus;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_BUSY,
        RD_DONE
    } RdState;

    typedef struct packed {
        logic overflow;
        logic lenfull;
        logic truncated;
        logic requested;
    } DropEvents;

    function automatic logic [15:0] satInc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/ingress_frame_fifo_if.sv
// Receive bus plus frame read-out handshake of the ingress frame FIFO.
interface ingress_frame_fifo_if;
    import ingress_frame_fifo_pkg::*;

    EthernetRxBus rx_bus;
    logic         frame_start;
    logic         frame_ready;
    logic [15:0]  frame_bytelen;
    logic         rd_valid;
    logic [31:0]  rd_data;
    logic         rd_frame_done;

    modport slave (
        input  rx_bus,
        input  frame_start,
        output frame_ready,
        output frame_bytelen,
        output rd_valid,
        output rd_data,
        output rd_frame_done
    );

    modport master (
        output rx_bus,
        output frame_start,
        input  frame_ready,
        input  frame_bytelen,
        input  rd_valid,
        input  rd_data,
        input  rd_frame_done
    );
endinterface

// File: rtl/ingress_frame_fifo_length.sv
// Single-clock FIFO of committed frame byte lengths; the head entry is visible without a pop.
module ingress_length_fifo
    import ingress_frame_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_MAX_FRAMES,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    rdPtr_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (wrPtr_q - rdPtr_q) == PW'(DEPTH);
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign head_o  = mem[rdPtr_q[AW-1:0]];
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/ingress_frame_fifo.sv
// Ingress frame FIFO: words are staged until commit, then read out as bursts of ceil(bytelen/4) words.
// Drop-reason counters are built only when INGRESS_FIFO_STATS_EN is defined.
module ingress_frame_fifo
    import ingress_frame_fifo_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int MAX_FRAMES = DEFAULT_MAX_FRAMES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                link_up,
    ingress_frame_fifo_if.slave bus
`ifdef INGRESS_FIFO_STATS_EN
    ,
    output logic [15:0]         drop_overflow,
    output logic [15:0]         drop_lenfull,
    output logic [15:0]         drop_truncated,
    output logic [15:0]         drop_requested
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] commitBase_q, commitBase_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [15:0]   byteLen_q, byteLen_d;
    logic          frameOpen_q, frameOpen_d;
    logic          poisoned_q, poisoned_d;
    logic [16:0]   lenSum;

    logic          ramWe;
    logic [AW-1:0] ramWrAddr;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   ramQ_q;

    logic          lenPush, lenPop, lenFull, lenEmpty;
    logic [15:0]   lenHead;

    RdState        state_q, state_d;
    logic [14:0]   wordsLeft_q, wordsLeft_d;
    logic          rdValid_q, rdValid_d;
    logic          rdDone_q, rdDone_d;
    logic          frameReady;

`ifdef INGRESS_FIFO_STATS_EN
    DropEvents     dropEv;
    logic [15:0]   dropOverflow_q, dropLenfull_q, dropTruncated_q, dropRequested_q;
`endif

    ingress_length_fifo #(
        .DEPTH(MAX_FRAMES),
        .WIDTH(16)
    ) u_lenFifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (lenPush),
        .data_i (byteLen_d),
        .pop_i  (lenPop),
        .full_o (lenFull),
        .empty_o(lenEmpty),
        .head_o (lenHead)
    );

    // Write side: each rx_bus event is applied in order (start, word, commit/drop) within one cycle.
    always_comb begin
        wrPtr_d      = wrPtr_q;
        commitBase_d = commitBase_q;
        byteLen_d    = byteLen_q;
        frameOpen_d  = frameOpen_q;
        poisoned_d   = poisoned_q;
        ramWe        = 1'b0;
        ramWrAddr    = wrPtr_q[AW-1:0];
        lenPush      = 1'b0;
        lenSum       = '0;
`ifdef INGRESS_FIFO_STATS_EN
        dropEv       = '0;
`endif
        if (!link_up) begin
            if (frameOpen_q) begin
                wrPtr_d     = commitBase_q;
                frameOpen_d = 1'b0;
`ifdef INGRESS_FIFO_STATS_EN
                dropEv.truncated = 1'b1;
`endif
            end
        end else begin
            if (bus.rx_bus.start) begin
                if (frameOpen_q) begin
                    wrPtr_d = commitBase_q;
`ifdef INGRESS_FIFO_STATS_EN
                    dropEv.truncated = 1'b1;
`endif
                end
                commitBase_d = wrPtr_d;
                byteLen_d    = '0;
                poisoned_d   = 1'b0;
                frameOpen_d  = 1'b1;
            end
            if (bus.rx_bus.data_valid && frameOpen_d) begin
                if ((wrPtr_d - rdPtr_q) == PW'(DEPTH)) begin
                    poisoned_d = 1'b1;
                end else begin
                    ramWe     = 1'b1;
                    ramWrAddr = wrPtr_d[AW-1:0];
                    wrPtr_d   = wrPtr_d + PW'(1);
                    lenSum    = {1'b0, byteLen_d} + 17'(bus.rx_bus.bytes_valid);
                    if (lenSum >= 17'h0FFFF) begin
                        byteLen_d  = 16'hFFFF;
                        poisoned_d = 1'b1;
                    end else begin
                        byteLen_d = lenSum[15:0];
                    end
                end
            end
            if (frameOpen_d && bus.rx_bus.drop) begin
                wrPtr_d     = commitBase_d;
                frameOpen_d = 1'b0;
`ifdef INGRESS_FIFO_STATS_EN
                dropEv.requested = 1'b1;
`endif
            end else if (frameOpen_d && bus.rx_bus.commit) begin
                frameOpen_d = 1'b0;
                if (poisoned_d) begin
                    wrPtr_d = commitBase_d;
`ifdef INGRESS_FIFO_STATS_EN
                    dropEv.overflow = 1'b1;
`endif
                end else if (lenFull) begin
                    wrPtr_d = commitBase_d;
`ifdef INGRESS_FIFO_STATS_EN
                    dropEv.lenfull = 1'b1;
`endif
                end else if (byteLen_d != 16'd0) begin
                    // Empty frames occupy no words, so they are closed without a length entry.
                    lenPush = 1'b1;
                end
            end
        end
    end

    // Read side: the RAM read is registered, so each word appears one cycle after it is issued.
    always_comb begin
        state_d     = state_q;
        rdPtr_d     = rdPtr_q;
        wordsLeft_d = wordsLeft_q;
        rdValid_d   = 1'b0;
        rdDone_d    = 1'b0;
        lenPop      = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (bus.frame_start && frameReady) begin
                    lenPop      = 1'b1;
                    wordsLeft_d = 15'((17'(lenHead) + 17'd3) >> 2);
                    state_d     = RD_BUSY;
                end
            end
            RD_BUSY: begin
                rdValid_d   = 1'b1;
                rdPtr_d     = rdPtr_q + PW'(1);
                wordsLeft_d = wordsLeft_q - 15'd1;
                if (wordsLeft_q == 15'd1) begin
                    rdDone_d = 1'b1;
                    state_d  = RD_DONE;
                end
            end
            RD_DONE: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q      <= '0;
            commitBase_q <= '0;
            rdPtr_q      <= '0;
            byteLen_q    <= '0;
            frameOpen_q  <= 1'b0;
            poisoned_q   <= 1'b0;
            state_q      <= RD_IDLE;
            wordsLeft_q  <= '0;
            rdValid_q    <= 1'b0;
            rdDone_q     <= 1'b0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            commitBase_q <= commitBase_d;
            rdPtr_q      <= rdPtr_d;
            byteLen_q    <= byteLen_d;
            frameOpen_q  <= frameOpen_d;
            poisoned_q   <= poisoned_d;
            state_q      <= state_d;
            wordsLeft_q  <= wordsLeft_d;
            rdValid_q    <= rdValid_d;
            rdDone_q     <= rdDone_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ramWe) begin
            mem[ramWrAddr] <= bus.rx_bus.data;
        end
        ramQ_q <= mem[rdPtr_q[AW-1:0]];
    end

`ifdef INGRESS_FIFO_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropOverflow_q  <= '0;
            dropLenfull_q   <= '0;
            dropTruncated_q <= '0;
            dropRequested_q <= '0;
        end else begin
            if (dropEv.overflow)  dropOverflow_q  <= satInc16(dropOverflow_q);
            if (dropEv.lenfull)   dropLenfull_q   <= satInc16(dropLenfull_q);
            if (dropEv.truncated) dropTruncated_q <= satInc16(dropTruncated_q);
            if (dropEv.requested) dropRequested_q <= satInc16(dropRequested_q);
        end
    end

    assign drop_overflow  = dropOverflow_q;
    assign drop_lenfull   = dropLenfull_q;
    assign drop_truncated = dropTruncated_q;
    assign drop_requested = dropRequested_q;
`endif

    assign frameReady         = (state_q == RD_IDLE) && !lenEmpty;
    assign bus.frame_ready    = frameReady;
    assign bus.frame_bytelen  = frameReady ? lenHead : 16'd0;
    assign bus.rd_valid       = rdValid_q;
    assign bus.rd_data        = rdValid_q ? ramQ_q : 32'd0;
    assign bus.rd_frame_done  = rdDone_q;

endmodule

// File: tb/tb_ingress_frame_fifo.sv
// Self-checking bench: three DUT sizes share one stimulus stream; a scoreboard holds expected lengths and words.
module tb_ingress_frame_fifo;
    import ingress_frame_fifo_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } ExpWord;

    logic         clk = 1'b0;
    logic         rst;
    logic         linkUp;
    logic         frameStart;
    EthernetRxBus rxBus;
    int           sel;
    int           errors = 0;
    int           checks = 0;

    ExpWord       expWords[$];
    logic [15:0]  expLens[$];
    logic [31:0]  txWords[$];

    logic         obsReady, obsValid, obsDone;
    logic [15:0]  obsLen;
    logic [31:0]  obsData;

    always #5 clk = ~clk;

    ingress_frame_fifo_if ifMain ();
    ingress_frame_fifo_if ifSmallDepth ();
    ingress_frame_fifo_if ifSmallLen ();

    assign ifMain.rx_bus            = rxBus;
    assign ifMain.frame_start       = frameStart;
    assign ifSmallDepth.rx_bus      = rxBus;
    assign ifSmallDepth.frame_start = frameStart;
    assign ifSmallLen.rx_bus        = rxBus;
    assign ifSmallLen.frame_start   = frameStart;

`ifdef INGRESS_FIFO_STATS_EN
    logic [2:0][15:0] statOvf, statLenFull, statTrunc, statReq;
    logic [15:0]      obsOvf, obsLenFull, obsTrunc, obsReq;
`endif

    ingress_frame_fifo dutMain (
        .clk(clk), .rst(rst), .link_up(linkUp), .bus(ifMain)
`ifdef INGRESS_FIFO_STATS_EN
        , .drop_overflow(statOvf[0]), .drop_lenfull(statLenFull[0])
        , .drop_truncated(statTrunc[0]), .drop_requested(statReq[0])
`endif
    );

    ingress_frame_fifo #(.DEPTH(8)) dutSmallDepth (
        .clk(clk), .rst(rst), .link_up(linkUp), .bus(ifSmallDepth)
`ifdef INGRESS_FIFO_STATS_EN
        , .drop_overflow(statOvf[1]), .drop_lenfull(statLenFull[1])
        , .drop_truncated(statTrunc[1]), .drop_requested(statReq[1])
`endif
    );

    ingress_frame_fifo #(.MAX_FRAMES(2)) dutSmallLen (
        .clk(clk), .rst(rst), .link_up(linkUp), .bus(ifSmallLen)
`ifdef INGRESS_FIFO_STATS_EN
        , .drop_overflow(statOvf[2]), .drop_lenfull(statLenFull[2])
        , .drop_truncated(statTrunc[2]), .drop_requested(statReq[2])
`endif
    );

    // Route the outputs of the DUT under test to one set of observation signals.
    always_comb begin
        obsReady = ifMain.frame_ready;
        obsLen   = ifMain.frame_bytelen;
        obsValid = ifMain.rd_valid;
        obsData  = ifMain.rd_data;
        obsDone  = ifMain.rd_frame_done;
        case (sel)
            1: begin
                obsReady = ifSmallDepth.frame_ready;
                obsLen   = ifSmallDepth.frame_bytelen;
                obsValid = ifSmallDepth.rd_valid;
                obsData  = ifSmallDepth.rd_data;
                obsDone  = ifSmallDepth.rd_frame_done;
            end
            2: begin
                obsReady = ifSmallLen.frame_ready;
                obsLen   = ifSmallLen.frame_bytelen;
                obsValid = ifSmallLen.rd_valid;
                obsData  = ifSmallLen.rd_data;
                obsDone  = ifSmallLen.rd_frame_done;
            end
            default: ;
        endcase
    end

`ifdef INGRESS_FIFO_STATS_EN
    always_comb begin
        obsOvf     = statOvf[0];
        obsLenFull = statLenFull[0];
        obsTrunc   = statTrunc[0];
        obsReq     = statReq[0];
        case (sel)
            1: begin
                obsOvf = statOvf[1]; obsLenFull = statLenFull[1];
                obsTrunc = statTrunc[1]; obsReq = statReq[1];
            end
            2: begin
                obsOvf = statOvf[2]; obsLenFull = statLenFull[2];
                obsTrunc = statTrunc[2]; obsReq = statReq[2];
            end
            default: ;
        endcase
    end
`endif

    task automatic doReset();
        rst        = 1'b1;
        rxBus      = '0;
        frameStart = 1'b0;
        linkUp     = 1'b1;
        expWords.delete();
        expLens.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // endKind: 0 commit, 1 drop, 2 leave the frame open.
    task automatic sendFrame(input int lastBytes, input int endKind, input bit expectKept,
                             input bit startWithCommit);
        int n = txWords.size();
        @(negedge clk);
        rxBus       = '0;
        rxBus.start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rxBus             = '0;
            rxBus.data_valid  = 1'b1;
            rxBus.data        = txWords[i];
            rxBus.bytes_valid = (i == n - 1) ? 3'(lastBytes) : 3'd4;
        end
        if (endKind != 2) begin
            @(negedge clk);
            rxBus        = '0;
            rxBus.commit = (endKind == 0);
            rxBus.drop   = (endKind == 1);
            frameStart   = startWithCommit;
        end
        @(negedge clk);
        rxBus      = '0;
        frameStart = 1'b0;
        if (expectKept && endKind == 0) begin
            expLens.push_back(16'((n - 1) * 4 + lastBytes));
            for (int i = 0; i < n; i++) begin
                expWords.push_back('{data: txWords[i], last: (i == n - 1)});
            end
        end
    endtask

    // Entered on the negedge just after the frame_start edge; consumes one frame from the scoreboard.
    task automatic collectFrame(input string name);
        ExpWord exp;
        checks++;
        if (obsValid !== 1'b0 || obsReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s latency: rd_valid=%b frame_ready=%b required 0 0", name, obsValid, obsReady);
        end
        @(negedge clk);
        for (int c = 0; c < 64; c++) begin
            checks++;
            if (obsValid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s stream: rd_valid=%b required 1 at word %0d", name, obsValid, c);
                return;
            end
            if (expWords.size() == 0) begin
                errors++;
                $display("[TB] FAIL %s extra word: got %h required none", name, obsData);
                return;
            end
            exp = expWords.pop_front();
            if (obsData !== exp.data || obsDone !== exp.last) begin
                errors++;
                $display("[TB] FAIL %s word %0d: data=%h done=%b required data=%h done=%b",
                         name, c, obsData, obsDone, exp.data, exp.last);
            end
            if (exp.last || obsDone === 1'b1) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s timeout: rd_frame_done not seen, required within 64 cycles", name);
    endtask

    task automatic readFrame(input string name);
        int          waited = 0;
        logic [15:0] expLen;
        while (obsReady !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (obsReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s ready: frame_ready=%b required 1", name, obsReady);
            return;
        end
        expLen = (expLens.size() != 0) ? expLens.pop_front() : 16'hxxxx;
        checks++;
        if (obsLen !== expLen) begin
            errors++;
            $display("[TB] FAIL %s bytelen: got %0d required %0d", name, obsLen, expLen);
        end
        frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
        collectFrame(name);
    endtask

    task automatic test_reset();
        doReset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if ({obsReady, obsValid, obsDone, obsLen, obsData} !== 51'd0) begin
                errors++;
                $display("[TB] FAIL reset dut%0d: ready=%b valid=%b done=%b len=%0d data=%h required all 0",
                         s, obsReady, obsValid, obsDone, obsLen, obsData);
            end
`ifdef INGRESS_FIFO_STATS_EN
            checks++;
            if ({obsOvf, obsLenFull, obsTrunc, obsReq} !== 64'd0) begin
                errors++;
                $display("[TB] FAIL reset stats dut%0d: %0d %0d %0d %0d required 0 0 0 0",
                         s, obsOvf, obsLenFull, obsTrunc, obsReq);
            end
`endif
        end
        sel = 0;
    endtask

    task automatic test_single_frame();
        sel = 0;
        doReset();
        txWords = '{32'hfeedface, 32'hdeadbeef, 32'hcafef00d, 32'hbaadc0de, 32'h41414100};
        sendFrame(3, 0, 1'b1, 1'b0);
        readFrame("single");
        @(negedge clk);
        checks++;
        if (obsValid !== 1'b0 || obsDone !== 1'b0 || obsReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single idle: valid=%b done=%b ready=%b required 0 0 0", obsValid, obsDone, obsReady);
        end
    endtask

    task automatic test_back_to_back();
        sel = 0;
        doReset();
        txWords = '{32'hfeedface, 32'hdeadbeef, 32'hcafef00d, 32'hbaadc0de, 32'h41414100};
        sendFrame(3, 0, 1'b1, 1'b0);
        txWords = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                    32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        sendFrame(4, 0, 1'b1, 1'b0);
        readFrame("b2b first");
        readFrame("b2b second");
    endtask

    task automatic test_overflow();
        sel = 1;
        doReset();
        txWords.delete();
        for (int i = 0; i < 12; i++) txWords.push_back(32'(32'h01010101 * (i + 1)));
        sendFrame(4, 0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (obsReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow ready: frame_ready=%b required 0", obsReady);
        end
`ifdef INGRESS_FIFO_STATS_EN
        checks++;
        if (obsOvf !== 16'd1) begin
            errors++;
            $display("[TB] FAIL overflow count: drop_overflow=%0d required 1", obsOvf);
        end
`endif
        txWords = '{32'ha5a5a5a5, 32'h5a5a5a5a};
        sendFrame(4, 0, 1'b1, 1'b0);
        readFrame("after overflow");
        sel = 0;
    endtask

    task automatic test_drop_truncate();
        sel = 0;
        doReset();
        txWords = '{32'h00000001, 32'h00000002, 32'h00000003};
        sendFrame(4, 1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (obsReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop ready: frame_ready=%b required 0", obsReady);
        end
        txWords = '{32'h0000aaaa, 32'h0000bbbb};
        sendFrame(4, 2, 1'b0, 1'b0);
        txWords = '{32'h12345678};
        sendFrame(4, 0, 1'b1, 1'b0);
`ifdef INGRESS_FIFO_STATS_EN
        checks++;
        if (obsReq !== 16'd1 || obsTrunc !== 16'd1) begin
            errors++;
            $display("[TB] FAIL drop counts: requested=%0d truncated=%0d required 1 1", obsReq, obsTrunc);
        end
`endif
        readFrame("after truncate");
        @(negedge clk);
        checks++;
        if (obsReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL truncate leftovers: frame_ready=%b required 0", obsReady);
        end
    endtask

    task automatic test_len_full();
        sel = 2;
        doReset();
        txWords = '{32'h10000001};
        sendFrame(4, 0, 1'b1, 1'b0);
        txWords = '{32'h20000002};
        sendFrame(4, 0, 1'b1, 1'b0);
        txWords = '{32'h30000003};
        sendFrame(4, 0, 1'b0, 1'b0);
`ifdef INGRESS_FIFO_STATS_EN
        checks++;
        if (obsLenFull !== 16'd1) begin
            errors++;
            $display("[TB] FAIL lenfull count: drop_lenfull=%0d required 1", obsLenFull);
        end
`endif
        readFrame("lenfull first");
        readFrame("lenfull second");
        repeat (2) @(negedge clk);
        checks++;
        if (obsReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lenfull third: frame_ready=%b required 0", obsReady);
        end
        sel = 0;
    endtask

    task automatic test_commit_with_start();
        logic [15:0] expLen;
        sel = 0;
        doReset();
        txWords = '{32'hc0c0c0c0, 32'hd0d0d0d0};
        sendFrame(4, 0, 1'b1, 1'b0);
        expLen = expLens.pop_front();
        checks++;
        if (obsReady !== 1'b1 || obsLen !== expLen) begin
            errors++;
            $display("[TB] FAIL concurrent head: ready=%b len=%0d required 1 %0d", obsReady, obsLen, expLen);
        end
        txWords = '{32'he0e0e0e0, 32'hf0f0f0f0, 32'h0a0b0c00};
        sendFrame(3, 0, 1'b1, 1'b1);
        collectFrame("concurrent A");
        readFrame("concurrent B");
    endtask

    task automatic test_link_down();
        sel = 0;
        doReset();
        txWords = '{32'h600dcafe};
        sendFrame(4, 0, 1'b1, 1'b0);
        txWords = '{32'hbad00001, 32'hbad00002};
        sendFrame(4, 2, 1'b0, 1'b0);
        linkUp = 1'b0;
        @(negedge clk);
        linkUp           = 1'b1;
        rxBus            = '0;
        rxBus.data_valid = 1'b1;
        rxBus.bytes_valid = 3'd4;
        rxBus.data       = 32'hbad00003;
        @(negedge clk);
        rxBus        = '0;
        rxBus.commit = 1'b1;
        @(negedge clk);
        rxBus = '0;
`ifdef INGRESS_FIFO_STATS_EN
        checks++;
        if (obsTrunc !== 16'd1) begin
            errors++;
            $display("[TB] FAIL linkdown count: drop_truncated=%0d required 1", obsTrunc);
        end
`endif
        readFrame("linkdown retained");
        repeat (2) @(negedge clk);
        checks++;
        if (obsReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL linkdown stray: frame_ready=%b required 0", obsReady);
        end
        txWords = '{32'h77665544, 32'h33221100};
        sendFrame(2, 0, 1'b1, 1'b0);
        readFrame("linkdown next");
    endtask

    task automatic test_reset_mid_readout();
        sel = 0;
        doReset();
        txWords = '{32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10, 32'h11121314};
        sendFrame(4, 0, 1'b1, 1'b0);
        frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
        @(negedge clk);
        checks++;
        if (obsValid !== 1'b1 || obsData !== 32'h01020304) begin
            errors++;
            $display("[TB] FAIL midreset first word: valid=%b data=%h required 1 01020304", obsValid, obsData);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({obsReady, obsValid, obsDone, obsLen, obsData} !== 51'd0) begin
            errors++;
            $display("[TB] FAIL midreset outputs: ready=%b valid=%b done=%b len=%0d data=%h required all 0",
                     obsReady, obsValid, obsDone, obsLen, obsData);
        end
        expWords.delete();
        expLens.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        txWords = '{32'h9abcdef0, 32'h13579bdf, 32'h2468ace0};
        sendFrame(4, 0, 1'b1, 1'b0);
        readFrame("after midreset");
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion within 2 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sel        = 0;
        rst        = 1'b1;
        linkUp     = 1'b1;
        frameStart = 1'b0;
        rxBus      = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_drop_truncate();
        test_len_full();
        test_commit_with_start();
        test_link_down();
        test_reset_mid_readout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ingress_frame_fifo.md
INGRESS_FRAME_FIFO -- requirements
Module: ingress_frame_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, data FIFO depth in 32-bit words (power of two).
REQ-002 The block SHALL have parameter MAX_FRAMES, default 32, length FIFO depth in frames (power of two).
REQ-003 The block SHALL have port clk  in  1  the single clock; one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port rst  in  1  asynchronous active-high reset.
REQ-005 The block SHALL have port link_up  in  1  PHY link state; low flushes any in-progress frame.
REQ-006 The block SHALL have port rx_bus  in  EthernetRxBus  start/data_valid/bytes_valid/data/commit/drop.
REQ-007 The block SHALL have port frame_ready  out  1  at least one committed frame is waiting.
REQ-008 The block SHALL have port frame_bytelen  out  16  byte length of the head frame, valid while frame_ready.
REQ-009 The block SHALL have port frame_start  in  1  consumer pop request, honoured only while frame_ready.
REQ-010 The block SHALL have ports rd_valid (out, 1), rd_data (out, 32) and rd_frame_done (out, 1), the read-out word stream.

Function
REQ-011 rx_bus.start SHALL latch wr_ptr into commit_base and clear the byte counter.
REQ-012 A data_valid word SHALL be written at wr_ptr, wr_ptr += 1, bytelen += bytes_valid (1..4).
REQ-013 On commit, if the frame is not poisoned and the length FIFO is not full, the block SHALL push bytelen and publish wr_ptr as the committed pointer in that same cycle.
REQ-014 On commit when poisoned, on length FIFO full, or on rx_bus.drop, the block SHALL restore wr_ptr to commit_base and increment the matching drop reason.
REQ-015 A data_valid word arriving while the data FIFO is full (wr_ptr - rd_ptr == DEPTH) SHALL NOT be written and SHALL poison the frame.
REQ-016 A start without a preceding commit/drop SHALL silently roll back the partial frame (reason: truncated) before beginning the new frame.
REQ-017 Any bytelen reaching 0xFFFF SHALL saturate and poison the frame.
REQ-018 Pointers SHALL be log2(DEPTH)+1 bits wide, compared with the wrap bit for the full/empty test.
REQ-019 The read side SHALL be a three-state machine: IDLE -> (frame_start & frame_ready) -> BUSY -> last word issued -> DONE -> IDLE.
REQ-020 frame_start SHALL pop the length FIFO.
REQ-021 rd_valid SHALL assert 2 cycles after frame_start (registered RAM read) for ceil(bytelen/4) consecutive cycles, with no back-pressure.
REQ-022 rd_frame_done SHALL be high together with the final rd_valid word.
REQ-023 frame_ready SHALL be low in BUSY and DONE, so a new frame_start is accepted no earlier than one cycle after rd_frame_done.
REQ-024 A commit and a frame_start in the same cycle SHALL both be honoured; the committed frame becomes visible the following cycle.
REQ-025 link_up low SHALL roll back any open frame (reason: truncated) and ignore rx_bus until the next start with link_up high; committed frames SHALL be retained.

Reset
REQ-026 On rst all pointers, counters and length FIFO state SHALL be 0, the FSM SHALL be IDLE, and frame_ready/rd_valid/rd_frame_done SHALL be 0 (frame_bytelen 0).
REQ-027 Reset mid-frame or mid-readout SHALL discard all contents; RAM contents need no reset.

Configuration
REQ-028 With INGRESS_FIFO_STATS_EN defined, the block SHALL add outputs drop_overflow, drop_lenfull, drop_truncated and drop_requested, each 16 bits, saturating and cleared by rst.
REQ-029 Without INGRESS_FIFO_STATS_EN, those ports and counters SHALL be absent and the drop behaviour SHALL be unchanged.

Structure
REQ-030 EthernetRxBus (with the drop bit) and the read FSM state enum SHALL live in the shared Ethernet package; the DEPTH/MAX_FRAMES defaults SHALL be package constants.
REQ-031 The length FIFO SHALL be a sub-module ingress_length_fifo (single-clock, 16-bit, MAX_FRAMES deep, push/pop/full/empty/head).

Verification
REQ-032 Scenario 1: frame feedface, deadbeef, cafef00d, baadc0de, 414141 (3 bytes), then commit -> frame_ready and frame_bytelen=19; after frame_start, 5 rd_valid words in order, with rd_frame_done on 0x41414100.
REQ-033 Scenario 2: back-to-back frames of 19 B and 32 B (11111111..88888888) -> two frames read in order, lengths 19 then 32.
REQ-034 Scenario 3: DEPTH=8, a 12-word frame with commit -> no frame_ready, wr_ptr restored, drop_overflow=1; a following 2-word frame is read correctly.
REQ-035 Scenario 4: start, 3 words, drop -> no frame_ready, drop_requested=1; start, 2 words, start, 1 word (4 bytes), commit -> drop_truncated=1 and one frame of 4 B.
REQ-036 Scenario 5: MAX_FRAMES=2, three committed 4-B frames with no reads -> third dropped (drop_lenfull=1), first two read intact.
REQ-037 Scenario 6: rst asserted during readout -> all outputs 0 immediately; a subsequent frame round-trips correctly.
